bitops_slot_alloc: RTL and testbench

BITOPS_SLOT_ALLOC -- requirements
Module: bitops_slot_alloc

---
 rtl/bitops_slot_alloc.sv | 135 +++++++++++++
 tb/tb_bitops_slot_alloc.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bitops_slot_alloc.sv
// Slot allocator: hands out free slots from an occupancy mask (lowest-first or
// round-robin) and releases them on request; single clock, async active-high reset.
module bitops_slot_alloc #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3,
    parameter int MODE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    input  logic              free_req,
    input  logic [IDXW-1:0]   free_idx,
    output logic              alloc_ack,
    output logic              alloc_nack,
    output logic [IDXW-1:0]   alloc_idx,
    output logic [WIDTH-1:0]  alloc_onehot,
    output logic [WIDTH-1:0]  busy,
    output logic [IDXW:0]     count,
    output logic              full
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDXW:0] c;
        c = {(IDXW+1){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{IDXW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Index of the lowest set bit; scanning downward lets the lowest one win.
    function automatic logic [IDXW-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] r;
        r = {IDXW{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            r = v[i] ? IDXW'(i) : r;
        end
        return r;
    endfunction

    logic [WIDTH-1:0] busy_r;
    logic [IDXW-1:0]  rr_ptr_r;
    logic             ack_r;
    logic             nack_r;
    logic [IDXW-1:0]  idx_r;
    logic [WIDTH-1:0] onehot_r;
    logic [IDXW:0]    count_r;
    logic             full_r;

    logic [IDXW-1:0]  start_s;
    logic [WIDTH-1:0] clear_s;
    logic [WIDTH-1:0] upper_s;
    logic             found_s;
    logic             grant_s;
    logic [IDXW-1:0]  grant_idx_s;
    logic [WIDTH-1:0] grant_onehot_s;
    logic [WIDTH-1:0] free_mask_s;
    logic [WIDTH-1:0] busy_next_s;

    // Find-first-clear over the pre-edge mask, rotated to start after the last grant in round-robin mode.
    always_comb begin
        start_s     = {IDXW{1'b0}};
        upper_s     = {WIDTH{1'b0}};
        grant_idx_s = {IDXW{1'b0}};
        if (MODE == 1) begin
            start_s = (rr_ptr_r == LAST_IDX) ? {IDXW{1'b0}} : rr_ptr_r + {{(IDXW-1){1'b0}}, 1'b1};
        end else begin
            start_s = {IDXW{1'b0}};
        end
        clear_s = ~busy_r;
        for (int i = 0; i < WIDTH; i++) begin
            upper_s[i] = clear_s[i] && (IDXW'(i) >= start_s);
        end
        found_s = |clear_s;
        if (|upper_s) begin
            grant_idx_s = lowest_set(upper_s);
        end else begin
            grant_idx_s = lowest_set(clear_s);
        end
    end

    // Decode grant and release into masks; out-of-range free indices match no bit and are dropped.
    always_comb begin
        grant_s        = alloc_req && found_s;
        grant_onehot_s = {WIDTH{1'b0}};
        free_mask_s    = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            grant_onehot_s[i] = grant_s && (grant_idx_s == IDXW'(i));
            free_mask_s[i]    = free_req && (free_idx == IDXW'(i));
        end
        busy_next_s = (busy_r & ~free_mask_s) | grant_onehot_s;
    end

    // Occupancy, pointer and grant/refuse response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r   <= {WIDTH{1'b0}};
            rr_ptr_r <= LAST_IDX;
            ack_r    <= 1'b0;
            nack_r   <= 1'b0;
            idx_r    <= {IDXW{1'b0}};
            onehot_r <= {WIDTH{1'b0}};
            count_r  <= {(IDXW+1){1'b0}};
            full_r   <= 1'b0;
        end else begin
            busy_r  <= busy_next_s;
            count_r <= popcount(busy_next_s);
            full_r  <= &busy_next_s;
            if (grant_s) begin
                ack_r    <= 1'b1;
                nack_r   <= 1'b0;
                idx_r    <= grant_idx_s;
                onehot_r <= grant_onehot_s;
                rr_ptr_r <= grant_idx_s;
            end else if (alloc_req) begin
                ack_r  <= 1'b0;
                nack_r <= 1'b1;
            end else begin
                ack_r  <= 1'b0;
                nack_r <= 1'b0;
            end
        end
    end

    assign alloc_ack    = ack_r;
    assign alloc_nack   = nack_r;
    assign alloc_idx    = idx_r;
    assign alloc_onehot = onehot_r;
    assign busy         = busy_r;
    assign count        = count_r;
    assign full         = full_r;

endmodule

// File: tb/tb_bitops_slot_alloc.sv
// Scoreboard bench: three allocators (lowest-first, round-robin, 6-slot) driven with
// directed vectors; a negedge monitor pops expected grant/refuse responses.
module tb_bitops_slot_alloc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] alloc_req = 3'b000;
    logic [2:0] free_req  = 3'b000;
    logic [2:0] free_idx [3];

    logic       ack0, ack1, ack2, nack0, nack1, nack2;
    logic [2:0] idx0, idx1, idx2;
    logic [7:0] oh0, oh1, busy0, busy1;
    logic [5:0] oh2, busy2;
    logic [3:0] cnt0, cnt1, cnt2;
    logic       full0, full1, full2;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q [3][$];

    always #5 clk = ~clk;

    bitops_slot_alloc #(.WIDTH(8), .IDXW(3), .MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .alloc_req(alloc_req[0]), .free_req(free_req[0]), .free_idx(free_idx[0]),
        .alloc_ack(ack0), .alloc_nack(nack0), .alloc_idx(idx0), .alloc_onehot(oh0),
        .busy(busy0), .count(cnt0), .full(full0));

    bitops_slot_alloc #(.WIDTH(8), .IDXW(3), .MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .alloc_req(alloc_req[1]), .free_req(free_req[1]), .free_idx(free_idx[1]),
        .alloc_ack(ack1), .alloc_nack(nack1), .alloc_idx(idx1), .alloc_onehot(oh1),
        .busy(busy1), .count(cnt1), .full(full1));

    bitops_slot_alloc #(.WIDTH(6), .IDXW(3), .MODE(0)) u_w6 (
        .clk(clk), .rst(rst), .alloc_req(alloc_req[2]), .free_req(free_req[2]), .free_idx(free_idx[2]),
        .alloc_ack(ack2), .alloc_nack(nack2), .alloc_idx(idx2), .alloc_onehot(oh2),
        .busy(busy2), .count(cnt2), .full(full2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kind: 0 = no response expected, 1 = ack with idx ei, 2 = nack
    task automatic step(input int d, input logic a, input logic f, input logic [2:0] fi,
                        input int kind, input logic [2:0] ei);
        logic [1:0] k;
        k = kind[1:0];
        alloc_req    = 3'b000;
        free_req     = 3'b000;
        alloc_req[d] = a;
        free_req[d]  = f;
        free_idx[d]  = fi;
        if (kind != 0) exp_q[d].push_back({k, ei});
        @(posedge clk);
        #1;
        alloc_req = 3'b000;
        free_req  = 3'b000;
    endtask

    task automatic mon(input int d, input logic ack, input logic nack,
                       input logic [2:0] idx, input logic [7:0] oh);
        logic [4:0] e;
        if (ack || nack) begin
            checks++;
            if (exp_q[d].size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp dut%0d: got ack=%0b nack=%0b idx=%0d expected none", d, ack, nack, idx);
            end else begin
                e = exp_q[d].pop_front();
                if ({nack, ack} != e[4:3] || (ack && idx != e[2:0])) begin
                    errors++;
                    $display("FAIL resp dut%0d: got nack=%0b ack=%0b idx=%0d expected kind=%0d idx=%0d",
                             d, nack, ack, idx, e[4:3], e[2:0]);
                end
                if (ack) begin
                    checks++;
                    if (oh != (8'd1 << idx)) begin
                        errors++;
                        $display("FAIL onehot dut%0d: got %0h expected %0h", d, oh, 8'd1 << idx);
                    end
                end
            end
        end
    endtask

    // Response monitor, decoupled from stimulus.
    always @(negedge clk) begin
        mon(0, ack0, nack0, idx0, oh0);
        mon(1, ack1, nack1, idx1, oh1);
        mon(2, ack2, nack2, idx2, {2'b00, oh2});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        free_idx[0] = 3'd0; free_idx[1] = 3'd0; free_idx[2] = 3'd0;
        #3;
        chk("rst_busy", 64'(busy0), 64'h0);
        chk("rst_count", 64'(cnt0), 64'h0);
        chk("rst_full", 64'(full1), 64'h0);
        chk("rst_outs", 64'({ack0, nack0, idx0, oh0}), 64'h0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Lowest-first: fill all 8, then refuse
        for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b0, 3'd0, 1, 3'(i));
        chk("m0_busy_full", 64'(busy0), 64'hFF);
        chk("m0_count8", 64'(cnt0), 64'd8);
        chk("m0_full", 64'(full0), 64'd1);
        step(0, 1'b1, 1'b0, 3'd0, 2, 3'd0);
        chk("m0_busy_after_nack", 64'(busy0), 64'hFF);
        step(0, 1'b0, 1'b1, 3'd3, 0, 3'd0);
        chk("m0_busy_free3", 64'(busy0), 64'hF7);
        chk("m0_count7", 64'(cnt0), 64'd7);
        chk("m0_notfull", 64'(full0), 64'd0);
        step(0, 1'b1, 1'b0, 3'd0, 1, 3'd3);
        chk("m0_refull", 64'(full0), 64'd1);
        // Simultaneous alloc + free when full: nack, free still lands
        step(0, 1'b1, 1'b1, 3'd5, 2, 3'd0);
        chk("m0_busy_DF", 64'(busy0), 64'hDF);
        step(0, 1'b1, 1'b0, 3'd0, 1, 3'd5);
        chk("m0_busy_FF", 64'(busy0), 64'hFF);

        // Round-robin: 0,1,2, free 0, then 3..7, wrap to 0
        for (int i = 0; i < 3; i++) step(1, 1'b1, 1'b0, 3'd0, 1, 3'(i));
        step(1, 1'b0, 1'b1, 3'd0, 0, 3'd0);
        for (int i = 3; i < 8; i++) step(1, 1'b1, 1'b0, 3'd0, 1, 3'(i));
        chk("m1_busy_FE", 64'(busy1), 64'hFE);
        step(1, 1'b1, 1'b0, 3'd0, 1, 3'd0);
        step(1, 1'b1, 1'b0, 3'd0, 2, 3'd0);
        step(1, 1'b0, 1'b1, 3'd2, 0, 3'd0);
        step(1, 1'b1, 1'b0, 3'd0, 1, 3'd2);
        chk("m1_busy_FF", 64'(busy1), 64'hFF);

        // 6-slot: ignored frees (clear slot, out of range), then a real one
        step(2, 1'b1, 1'b0, 3'd0, 1, 3'd0);
        step(2, 1'b1, 1'b0, 3'd0, 1, 3'd1);
        step(2, 1'b0, 1'b1, 3'd4, 0, 3'd0);
        chk("w6_busy_clearfree", 64'(busy2), 64'h03);
        step(2, 1'b0, 1'b1, 3'd7, 0, 3'd0);
        chk("w6_busy_oor", 64'(busy2), 64'h03);
        chk("w6_count_oor", 64'(cnt2), 64'd2);
        step(2, 1'b0, 1'b1, 3'd1, 0, 3'd0);
        chk("w6_busy_free1", 64'(busy2), 64'h01);
        chk("w6_count1", 64'(cnt2), 64'd1);

        // Mid-cycle reset during a burst
        step(0, 1'b0, 1'b1, 3'd0, 0, 3'd0);
        step(0, 1'b0, 1'b1, 3'd1, 0, 3'd0);
        step(1, 1'b0, 1'b1, 3'd4, 0, 3'd0);
        step(1, 1'b0, 1'b1, 3'd5, 0, 3'd0);
        step(0, 1'b1, 1'b0, 3'd0, 1, 3'd0);
        alloc_req = 3'b011;
        @(posedge clk); #1;
        alloc_req = 3'b000;
        chk("burst_ack_live", 64'({ack0, idx0, ack1, idx1}), 64'({1'b1, 3'd1, 1'b1, 3'd4}));
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_m0", 64'({ack0, nack0, idx0, oh0, busy0, cnt0, full0}), 64'h0);
        chk("rst_mid_m1", 64'({ack1, nack1, idx1, oh1, busy1, cnt1, full1}), 64'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        step(0, 1'b0, 1'b0, 3'd0, 0, 3'd0);
        exp_q[0].push_back({2'b01, 3'd0});
        exp_q[1].push_back({2'b01, 3'd0});
        alloc_req = 3'b011;
        @(posedge clk); #1;
        alloc_req = 3'b000;
        chk("post_rst_busy0", 64'(busy0), 64'h01);
        chk("post_rst_busy1", 64'(busy1), 64'h01);

        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk("pending_resp", 64'(exp_q[d].size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
